// File: rtl/soc_system_prng_ctrl_pkg.sv
// soc_system_prng_ctrl_pkg
// Shared definitions for the PRNG bring-up sequencer. This file has no ports.
// It holds:
//   - the sequencer state enum
//   - the Avalon-MM register word addresses
//   - the bit positions inside the CTRL and STATUS registers
package soc_system_prng_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4
  } prng_state_e;

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_SEED      = 2'd1;
  localparam logic [1:0] ADDR_STATUS    = 2'd2;
  localparam logic [1:0] ADDR_RESET_LEN = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_STOP_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_RUNNING_BIT = 1;
  localparam int STATUS_DONE_BIT    = 2;

endpackage

// File: rtl/soc_system_prng_ctrl_fsm.sv
// soc_system_prng_ctrl_fsm
// Purpose:
//   Sequencer that takes the PRNG through its bring-up states:
//   IDLE -> RESET -> LOAD -> SETTLE -> RUN.
//   It holds the state register, the shared 8-bit down-counter and the
//   output decode.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i, stop_i    : one-cycle command pulses (stop has priority)
//   resetLen_i         : reset hold length; a value of 0 is treated as 1
//   prngReset_o        : high in IDLE and RESET
//   seedLoad_o         : high in LOAD
//   enable_o           : high in RUN
//   busy_o, running_o  : status decode
//   seqStart_o         : pulse on every edge that enters RESET (seed latch)
//   doneSet_o          : pulse on the SETTLE -> RUN edge
module soc_system_prng_ctrl_fsm
  import soc_system_prng_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [7:0] resetLen_i,
  output logic       prngReset_o,
  output logic       seedLoad_o,
  output logic       enable_o,
  output logic       busy_o,
  output logic       running_o,
  output logic       seqStart_o,
  output logic       doneSet_o
);

  prng_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // The counter holds "cycles remaining minus one" in the current timed state.
  // The state is left on the edge where the counter reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. STOP is checked before everything else, so a combined
  // START+STOP write acts as a plain STOP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seqStart_o = 1'b0;
    doneSet_o  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          state_d    = RESET;
          cnt_d      = (resetLen_i == 8'd0) ? 8'd0 : resetLen_i - 8'd1;
          seqStart_o = 1'b1;
        end
      end
      RESET: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOAD: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
          cnt_d   = 8'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d   = RUN;
          doneSet_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The outputs depend only on the registered state, so they are glitch-free.
  always_comb begin
    prngReset_o = (state_q == IDLE) || (state_q == RESET);
    seedLoad_o  = (state_q == LOAD);
    enable_o    = (state_q == RUN);
    busy_o      = (state_q == RESET) || (state_q == LOAD) || (state_q == SETTLE);
    running_o   = (state_q == RUN);
  end

endmodule

// File: rtl/soc_system_prng_ctrl.sv
// soc_system_prng_ctrl
// Purpose:
//   Avalon-MM register front end for the PRNG bring-up sequencer.
//   It holds the register file, the read mux and the optional IRQ logic.
// Configuration macro:
//   SOC_PRNG_CTRL_IRQ_EN
//     defined   : IRQ_EN is R/W and irq is DONE & IRQ_EN, registered.
//     undefined : IRQ_EN reads 0 and irq is tied to 0.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata         : Avalon-MM slave write side
//   readdata                   : combinational read data, zero wait states
//   prng_reset, prng_seed,
//   prng_seed_load, prng_enable: PRNG core controls
//   irq                        : level interrupt
module soc_system_prng_ctrl
  import soc_system_prng_ctrl_pkg::*;
#(
  parameter int          RESET_LEN_DEFAULT = 16,
  parameter int          SETTLE_CYCLES     = 4,
  parameter logic [31:0] SEED_DEFAULT      = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        prng_reset,
  output logic [31:0] prng_seed,
  output logic        prng_seed_load,
  output logic        prng_enable,
  output logic        irq
);

  logic        regWrite;
  logic [31:0] seed_q;
  logic [7:0]  resetLen_q;
  logic        done_q, done_d;
  logic        irqEn_q;
  logic        startReq_q, stopReq_q;
  logic [31:0] prngSeed_q;
  logic        busy, running, seqStart, doneSet;

  assign regWrite = chipselect && !write_n;

  // DONE is sticky. The set from the sequencer beats a coincident W1C.
  always_comb begin
    done_d = done_q;
    if (regWrite && address == ADDR_STATUS && writedata[STATUS_DONE_BIT]) begin
      done_d = 1'b0;
    end
    if (doneSet) begin
      done_d = 1'b1;
    end
  end

  // Register file. CTRL command bits are captured as one-cycle pulses that
  // the sequencer acts on at the following edge. The seed is copied to the
  // PRNG only when a sequence starts, so SEED writes mid-sequence wait for
  // the next START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q     <= SEED_DEFAULT;
      resetLen_q <= 8'(RESET_LEN_DEFAULT);
      done_q     <= 1'b0;
      startReq_q <= 1'b0;
      stopReq_q  <= 1'b0;
      prngSeed_q <= SEED_DEFAULT;
    end else begin
      startReq_q <= regWrite && address == ADDR_CTRL && writedata[CTRL_START_BIT];
      stopReq_q  <= regWrite && address == ADDR_CTRL && writedata[CTRL_STOP_BIT];
      done_q     <= done_d;
      if (regWrite && address == ADDR_SEED) begin
        seed_q <= writedata;
      end
      if (regWrite && address == ADDR_RESET_LEN) begin
        resetLen_q <= writedata[7:0];
      end
      if (seqStart) begin
        prngSeed_q <= seed_q;
      end
    end
  end

`ifdef SOC_PRNG_CTRL_IRQ_EN
  logic irq_q;

  // The interrupt enable and a registered copy of DONE & IRQ_EN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqEn_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= done_q && irqEn_q;
      if (regWrite && address == ADDR_CTRL) begin
        irqEn_q <= writedata[CTRL_IRQ_EN_BIT];
      end
    end
  end

  assign irq = irq_q;
`else
  assign irqEn_q = 1'b0;
  assign irq     = 1'b0;
`endif

  // Read mux. It only looks at current register state, so a read during a
  // write returns the value from before the write.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:      readdata[CTRL_IRQ_EN_BIT] = irqEn_q;
      ADDR_SEED:      readdata = seed_q;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT]    = busy;
        readdata[STATUS_RUNNING_BIT] = running;
        readdata[STATUS_DONE_BIT]    = done_q;
      end
      default:        readdata[7:0] = resetLen_q;
    endcase
  end

  soc_system_prng_ctrl_fsm #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_fsm (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .start_i    (startReq_q),
    .stop_i     (stopReq_q),
    .resetLen_i (resetLen_q),
    .prngReset_o(prng_reset),
    .seedLoad_o (prng_seed_load),
    .enable_o   (prng_enable),
    .busy_o     (busy),
    .running_o  (running),
    .seqStart_o (seqStart),
    .doneSet_o  (doneSet)
  );

  assign prng_seed = prngSeed_q;

endmodule

// File: tb/tb_soc_system_prng_ctrl.sv
// tb_soc_system_prng_ctrl
// Self-checking bench for soc_system_prng_ctrl. The reference model describes
// a sequence as a schedule: the edge where it started, the reset length and
// the seed it latched. The expected outputs in any cycle follow from the
// distance to that start edge.
module tb_soc_system_prng_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        prng_reset;
  logic [31:0] prng_seed;
  logic        prng_seed_load;
  logic        prng_enable;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          tNow;
  int          seqStartEdge;
  int          lenUsed;
  bit          active;
  logic [31:0] seedReg, seedLat;
  logic [7:0]  lenReg;
  bit          irqEnM, doneM, irqM, pendStart, pendStop;

  soc_system_prng_ctrl #(
    .RESET_LEN_DEFAULT(16),
    .SETTLE_CYCLES(SETTLE),
    .SEED_DEFAULT(32'h0000_0001)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .prng_reset(prng_reset),
    .prng_seed(prng_seed),
    .prng_seed_load(prng_seed_load),
    .prng_enable(prng_enable),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Phase after edge t: 0 idle, 1 reset, 2 load, 3 settle, 4 run.
  function automatic int phaseAt(int t);
    int d;
    if (!active) return 0;
    d = t - seqStartEdge;
    if (d < lenUsed) return 1;
    if (d == lenUsed) return 2;
    if (d < lenUsed + 1 + SETTLE) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] expRead(logic [1:0] a);
    int p;
    p = phaseAt(tNow);
    case (a)
      2'd0:    return {29'd0, irqEnM, 2'b00};
      2'd1:    return seedReg;
      2'd2:    return {29'd0, doneM, (p == 4), (p >= 1 && p <= 3)};
      default: return {24'd0, lenReg};
    endcase
  endfunction

  task automatic modelReset();
    tNow = 0; seqStartEdge = 0; lenUsed = 1; active = 0;
    seedReg = 32'h1; seedLat = 32'h1; lenReg = 8'd16;
    irqEnM = 0; doneM = 0; irqM = 0; pendStart = 0; pendStop = 0;
  endtask

  // Advances the model across one rising edge with the sampled bus inputs.
  task automatic modelEdge(bit cs, bit wn, logic [1:0] a, logic [31:0] d);
    int  cur;
    bit  doneOld, irqEnOld, doneSet, wr;
    cur      = phaseAt(tNow);
    doneOld  = doneM;
    irqEnOld = irqEnM;
    tNow++;
    if (pendStop && cur != 0) begin
      active = 0;
    end else if (pendStart && !pendStop && (cur == 0 || cur == 4)) begin
      active       = 1;
      seqStartEdge = tNow;
      lenUsed      = (lenReg == 0) ? 1 : int'(lenReg);
      seedLat      = seedReg;
    end
    doneSet   = active && (tNow - seqStartEdge == lenUsed + 1 + SETTLE);
    wr        = cs && !wn;
    pendStart = wr && a == 2'd0 && d[0];
    pendStop  = wr && a == 2'd0 && d[1];
`ifdef SOC_PRNG_CTRL_IRQ_EN
    irqM = doneOld && irqEnOld;
    if (wr && a == 2'd0) irqEnM = d[2];
`else
    irqM = 0;
`endif
    doneM = doneSet || (doneOld && !(wr && a == 2'd2 && d[2]));
    if (wr && a == 2'd1) seedReg = d;
    if (wr && a == 2'd3) lenReg = d[7:0];
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    int p;
    p = phaseAt(tNow);
    checkOutput("readdata", readdata, expRead(address));
    checkOutput("prng_reset", {31'd0, prng_reset}, {31'd0, (p <= 1)});
    checkOutput("prng_seed_load", {31'd0, prng_seed_load}, {31'd0, (p == 2)});
    checkOutput("prng_enable", {31'd0, prng_enable}, {31'd0, (p == 4)});
    checkOutput("prng_seed", prng_seed, seedLat);
    checkOutput("irq", {31'd0, irq}, {31'd0, irqM});
  endtask

  // One bus cycle: drive at the falling edge, check, then cross the rising edge.
  task automatic applyStimulus(bit cs, bit wn, logic [1:0] a, logic [31:0] d);
    @(negedge clk);
    chipselect = cs; write_n = wn; address = a; writedata = d;
    #1;
    checkAll();
    @(posedge clk);
    modelEdge(cs, wn, a, d);
  endtask

  task automatic idleCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 2'd2, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    modelReset();
    #12;
    address = 2'd1;
    #1 checkAll();
    address = 2'd3;
    #1 checkAll();
    @(negedge clk);
    reset_n = 1'b1;

    // Default length and seed, run to completion.
    applyStimulus(1, 0, 2'd0, 32'h1);
    idleCycles(26);

    // Shortest reset with a new seed.
    applyStimulus(1, 0, 2'd3, 32'h0);
    applyStimulus(1, 0, 2'd1, 32'hDEADBEEF);
    applyStimulus(1, 0, 2'd2, 32'h4);
    applyStimulus(1, 0, 2'd0, 32'h1);
    idleCycles(12);

    // Abort during settle: enable never rises, DONE stays clear.
    applyStimulus(1, 0, 2'd0, 32'h2);
    applyStimulus(1, 0, 2'd2, 32'h4);
    applyStimulus(1, 0, 2'd0, 32'h1);
    idleCycles(4);
    applyStimulus(1, 0, 2'd0, 32'h2);
    idleCycles(8);

    // START+STOP from idle, then from run.
    applyStimulus(1, 0, 2'd0, 32'h3);
    idleCycles(4);
    applyStimulus(1, 0, 2'd0, 32'h1);
    idleCycles(10);
    applyStimulus(1, 0, 2'd0, 32'h3);
    idleCycles(4);

    // Interrupt enable, completion, then W1C of DONE.
    applyStimulus(1, 0, 2'd0, 32'h4);
    applyStimulus(1, 0, 2'd0, 32'h5);
    idleCycles(12);
    applyStimulus(1, 0, 2'd2, 32'h4);
    idleCycles(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      applyStimulus(1'($urandom), 1'b1, 2'($urandom), $urandom);
      else if (r < 72) applyStimulus(1'b1, 1'b0, 2'd0, {29'd0, 1'($urandom), 1'b0, 1'b1});
      else if (r < 76) applyStimulus(1'b1, 1'b0, 2'd0, {29'd0, 3'($urandom)});
      else if (r < 84) applyStimulus(1'b1, 1'b0, 2'd1, $urandom);
      else if (r < 91) applyStimulus(1'b1, 1'b0, 2'd3, {$urandom, 3'($urandom_range(0, 6))});
      else if (r < 97) applyStimulus(1'b1, 1'b0, 2'd2, $urandom);
      else             applyStimulus(1'b1, 1'b0, 2'd0, 32'h2);
    end

    // Asynchronous reset while in the RESET state.
    applyStimulus(1, 0, 2'd1, 32'h12345678);
    applyStimulus(1, 0, 2'd3, 32'd20);
    applyStimulus(1, 0, 2'd0, 32'h1);
    idleCycles(5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 modelReset();
    address = 2'd1;
    #1 checkAll();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd1, 32'd0);
    idleCycles(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
